// File: rtl/timer_clock_div_pkg.sv
// Shared timer constants and a helper for sizing clock dividers.
package timer_clock_div_pkg;

  localparam int unsigned CLK_FREQ_HZ         = 50000000;
  localparam int unsigned DEFAULT_HALF_PERIOD = 25000000;

  // Half-period in CLK_IN cycles for a 50 % square wave at freq_hz.
  function automatic int unsigned half_period_for(input int unsigned freq_hz);
    return CLK_FREQ_HZ / (2 * freq_hz);
  endfunction

endpackage

// File: rtl/timer_clock_div.sv
// Free-running divider: 50 % duty CLK_OUT plus a one-cycle TICK on each CLK_OUT rise.
module timer_clock_div
  import timer_clock_div_pkg::*;
#(
  parameter int HALF_PERIOD = int'(DEFAULT_HALF_PERIOD)
) (
  input  logic CLK_IN,
  input  logic RST_N,
  input  logic EN,
  output logic CLK_OUT,
  output logic TICK
);

  localparam int CNT_W = (HALF_PERIOD > 1) ? $clog2(HALF_PERIOD) : 1;

  if (HALF_PERIOD < 1) begin : gen_bad_half_period
    $error("timer_clock_div: HALF_PERIOD must be >= 1");
  end

  localparam logic [CNT_W-1:0] TermCnt = CNT_W'(HALF_PERIOD - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             clk_out_q, clk_out_d;
  logic             tick_q, tick_d;

  // Explicit wrap at TermCnt so the counter never runs past HALF_PERIOD-1.
  always_comb begin
    cnt_d     = cnt_q;
    clk_out_d = clk_out_q;
    tick_d    = 1'b0;
    if (EN) begin
      if (cnt_q == TermCnt) begin
        cnt_d     = '0;
        clk_out_d = ~clk_out_q;
        tick_d    = ~clk_out_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      cnt_q     <= '0;
      clk_out_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      clk_out_q <= clk_out_d;
      tick_q    <= tick_d;
    end
  end

  assign CLK_OUT = clk_out_q;
  assign TICK    = tick_q;

endmodule

// File: tb/tb_timer_clock_div.sv
// Directed bench for timer_clock_div at HALF_PERIOD=4 and HALF_PERIOD=1.
module tb_timer_clock_div;

  logic clk;
  logic rst_n_a, en_a, clk_out_a, tick_a;
  logic rst_n_b, en_b, clk_out_b, tick_b;
  int   errors;
  int   checks;

  timer_clock_div #(.HALF_PERIOD(4)) u_dut_a (
    .CLK_IN (clk),
    .RST_N  (rst_n_a),
    .EN     (en_a),
    .CLK_OUT(clk_out_a),
    .TICK   (tick_a)
  );

  timer_clock_div #(.HALF_PERIOD(1)) u_dut_b (
    .CLK_IN (clk),
    .RST_N  (rst_n_b),
    .EN     (en_b),
    .CLK_OUT(clk_out_b),
    .TICK   (tick_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic reset_a;
    rst_n_a = 1'b0;
    en_a    = 1'b1;
    repeat (2) @(negedge clk);
    rst_n_a = 1'b1;
  endtask

  task automatic test_reset;
    logic exp_out, exp_tick;
    rst_n_a = 1'b0;
    en_a    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (clk_out_a !== 1'b0 || tick_a !== 1'b0) begin
        errors++;
        $display("FAIL reset_hold cyc=%0d clk_out=%b tick=%b want 0 0", i, clk_out_a, tick_a);
      end
    end
    rst_n_a = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      exp_out  = ((k / 4) % 2) == 1;
      exp_tick = (k % 8) == 4;
      checks++;
      if (clk_out_a !== exp_out || tick_a !== exp_tick) begin
        errors++;
        $display("FAIL reset_phase edge=%0d clk_out=%b tick=%b want %b %b",
                 k, clk_out_a, tick_a, exp_out, exp_tick);
      end
    end
  endtask

  task automatic test_steady;
    int   rises, falls, highs, ticks, last_rise;
    logic prev;
    rises = 0; falls = 0; highs = 0; ticks = 0; last_rise = 0; prev = 1'b0;
    reset_a();
    for (int k = 1; k <= 40; k++) begin
      step();
      if (clk_out_a === 1'b1) highs++;
      if (tick_a === 1'b1) ticks++;
      if (clk_out_a === 1'b1 && prev === 1'b0) begin
        rises++;
        if (last_rise != 0) begin
          checks++;
          if (k - last_rise != 8) begin
            errors++;
            $display("FAIL steady_period edge=%0d period=%0d want 8", k, k - last_rise);
          end
        end
        last_rise = k;
      end
      if (clk_out_a === 1'b0 && prev === 1'b1) falls++;
      prev = clk_out_a;
    end
    checks++;
    if (rises != 5 || falls != 5) begin
      errors++;
      $display("FAIL steady_edges rises=%0d falls=%0d want 5 5", rises, falls);
    end
    checks++;
    if (highs != 20) begin
      errors++;
      $display("FAIL steady_duty high_cycles=%0d want 20", highs);
    end
    checks++;
    if (ticks != 5) begin
      errors++;
      $display("FAIL steady_ticks ticks=%0d want 5", ticks);
    end
  endtask

  task automatic test_enable;
    reset_a();
    step();
    step();
    en_a = 1'b0;
    for (int k = 3; k <= 7; k++) begin
      step();
      checks++;
      if (clk_out_a !== 1'b0 || tick_a !== 1'b0) begin
        errors++;
        $display("FAIL en_gap_low edge=%0d clk_out=%b tick=%b want 0 0", k, clk_out_a, tick_a);
      end
    end
    en_a = 1'b1;
    step();
    checks++;
    if (clk_out_a !== 1'b0) begin
      errors++;
      $display("FAIL en_edge8 clk_out=%b want 0", clk_out_a);
    end
    step();
    checks++;
    if (clk_out_a !== 1'b1 || tick_a !== 1'b1) begin
      errors++;
      $display("FAIL en_rise9 clk_out=%b tick=%b want 1 1", clk_out_a, tick_a);
    end
    // Freeze while high: CLK_OUT must hold 1 and TICK must not repeat.
    en_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (clk_out_a !== 1'b1 || tick_a !== 1'b0) begin
        errors++;
        $display("FAIL en_gap_high cyc=%0d clk_out=%b tick=%b want 1 0", i, clk_out_a, tick_a);
      end
    end
    en_a = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++;
      if (clk_out_a !== (k < 4)) begin
        errors++;
        $display("FAIL en_resume_fall edge=%0d clk_out=%b want %b", k, clk_out_a, (k < 4));
      end
    end
  endtask

  task automatic test_div2;
    logic exp;
    rst_n_b = 1'b0;
    en_b    = 1'b1;
    @(negedge clk);
    checks++;
    if (clk_out_b !== 1'b0 || tick_b !== 1'b0) begin
      errors++;
      $display("FAIL div2_reset clk_out=%b tick=%b want 0 0", clk_out_b, tick_b);
    end
    rst_n_b = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      exp = (k % 2) == 1;
      checks++;
      if (clk_out_b !== exp || tick_b !== exp) begin
        errors++;
        $display("FAIL div2 edge=%0d clk_out=%b tick=%b want %b %b",
                 k, clk_out_b, tick_b, exp, exp);
      end
    end
  endtask

  task automatic test_async_reset;
    reset_a();
    for (int k = 1; k <= 4; k++) step();
    checks++;
    if (clk_out_a !== 1'b1 || tick_a !== 1'b1) begin
      errors++;
      $display("FAIL async_pre clk_out=%b tick=%b want 1 1", clk_out_a, tick_a);
    end
    #2 rst_n_a = 1'b0;
    #1;
    checks++;
    if (clk_out_a !== 1'b0 || tick_a !== 1'b0) begin
      errors++;
      $display("FAIL async_drop clk_out=%b tick=%b want 0 0", clk_out_a, tick_a);
    end
    @(negedge clk);
    rst_n_a = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      step();
      checks++;
      if (clk_out_a !== (k == 4)) begin
        errors++;
        $display("FAIL async_restart edge=%0d clk_out=%b want %b", k, clk_out_a, (k == 4));
      end
    end
  endtask

  initial begin
    errors  = 0;
    checks  = 0;
    rst_n_a = 1'b0;
    en_a    = 1'b1;
    rst_n_b = 1'b0;
    en_b    = 1'b1;
    test_reset();
    test_steady();
    test_enable();
    test_div2();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/timer_clock_div.md
Name: timer_clock_div

Overview:
- Free-running clock divider producing a slow, 50 % duty square wave (CLK_OUT) from the system clock.
- Used as the time base for human-visible timers, e.g. the open-door blinker, which toggles its light on each CLK_OUT rising edge.
- Also provides a single-cycle synchronous tick (TICK) aligned with each CLK_OUT rising edge. Consumers in the CLK_IN domain should prefer TICK over clocking logic from CLK_OUT.

Parameters:
- HALF_PERIOD, 25000000, number of enabled CLK_IN cycles per CLK_OUT half-period. CLK_OUT period = 2*HALF_PERIOD cycles; the default gives 1 Hz from 50 MHz. Must be >= 1; elaboration fails otherwise.
- CNT_W, max(1, clog2(HALF_PERIOD)), width of the internal cycle counter. Derived; not overridden by users.

Ports:
- CLK_IN  input  1  system clock; all state updates on its rising edge.
- RST_N  input  1  reset, asynchronous assert, active-low.
- EN  input  1  count enable; when low, all state freezes.
- CLK_OUT  output  1  divided clock, registered, glitch-free, 50 % duty.
- TICK  output  1  one-CLK_IN-cycle pulse, high in the same cycle CLK_OUT becomes 1.

Behaviour:
- Reset (RST_N low, asynchronous): counter = 0, CLK_OUT = 0, TICK = 0, held while RST_N is low. Release takes effect at the next CLK_IN rising edge.
- Each CLK_IN rising edge with EN = 1:
  - counter < HALF_PERIOD-1: counter increments; CLK_OUT holds; TICK = 0.
  - counter == HALF_PERIOD-1 (terminal): counter wraps to 0; CLK_OUT toggles; TICK = 1 if CLK_OUT toggles 0->1, else 0.
- EN = 0: counter and CLK_OUT hold their values; TICK = 0. The phase resumes exactly where it stopped.
- Latency after reset release with EN held at 1:
  - The first CLK_OUT rise occurs at the HALF_PERIOD-th active edge.
  - Falls occur at 2*HALF_PERIOD, rises at 3*HALF_PERIOD, and so on.
- HALF_PERIOD = 1: CLK_OUT toggles on every enabled edge (divide by 2); TICK is high on every other enabled cycle.
- All outputs are driven directly from flops; there is no combinational path from EN to any output.
- Counter never exceeds HALF_PERIOD-1. Wrap-around is explicit, not natural overflow.
- Reset asserted mid-period: immediate return to reset values. A partial half-period is discarded.

Decomposition:
- Shared timer package holds:
  - CLK_FREQ_HZ = 50000000
  - default HALF_PERIOD constant
  - helper function to compute HALF_PERIOD from a target output frequency
- No sub-module: a single counter plus a toggle flop.

Test Plan:
- Reset and phase, HALF_PERIOD=4, EN=1, RST_N low for 3 cycles then high:
  - CLK_OUT=0 and TICK=0 during reset.
  - CLK_OUT rises at edge 4 after release and falls at edge 8.
  - TICK=1 only in the cycle after edge 4 and after edge 12.
- Steady state, HALF_PERIOD=4, run 40 cycles -> exactly 5 full CLK_OUT periods, each 8 cycles with 4 high, and exactly 5 TICK pulses.
- Enable gating, HALF_PERIOD=4:
  - Drop EN for 5 cycles after edge 2.
  - CLK_OUT and TICK frozen during the gap.
  - First rise occurs at edge 4+5=9.
- Divide-by-2, HALF_PERIOD=1 -> CLK_OUT toggles every cycle; TICK high in alternating cycles.
- Asynchronous reset mid-high, HALF_PERIOD=4, pulse RST_N low between clock edges while CLK_OUT=1:
  - CLK_OUT drops to 0 immediately, without waiting for a clock edge.
  - After release, the first rise occurs 4 edges later.
